// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : reg_wb_arbiter                                                  |
// | Two-requester register-file writeback arbiter: per-requester FIFOs,      |
// | round-robin retire, WAW interlock and pending-write read scoreboard.     |
// | Option : REG_WB_BYPASS_EN forwards the retiring write to rs/rt reads.    |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module reg_wb_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_rw,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_rd_data,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [DATA_W-1:0] rf_rs_data,
    input  logic [DATA_W-1:0] rf_rt_data,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              idle
);

    localparam int C_PTR_W  = $clog2(DEPTH);
    localparam int C_CNT_W  = C_PTR_W + 1;
    localparam int C_PEND_W = C_CNT_W + 1;
    localparam int C_NREG   = 1 << ADDR_W;
    localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_t;

    // Index 0 is requester A, index 1 is requester B throughout.
    logic [ADDR_W-1:0]  r_rd   [2][DEPTH];
    logic [DATA_W-1:0]  r_data [2][DEPTH];
    logic [C_PTR_W-1:0] r_wp   [2];
    logic [C_PTR_W-1:0] r_rp   [2];
    logic [C_CNT_W-1:0] r_cnt  [2];
    pri_t               r_pri;

    logic [1:0]         w_in_valid;
    logic [ADDR_W-1:0]  w_in_rd   [2];
    logic [DATA_W-1:0]  w_in_data [2];
    logic [DEPTH-1:0]   w_slot_vld [2];
    logic [1:0]         w_other_has;
    logic [1:0]         w_full;
    logic [1:0]         w_ready;
    logic [1:0]         w_push;
    logic [1:0]         w_pop;
    logic [1:0]         w_head_vld;
    logic               w_gnt_vld;
    logic               w_gnt;
    logic [ADDR_W-1:0]  w_head_rd;
    logic [DATA_W-1:0]  w_head_data;
    logic [C_PEND_W-1:0] w_pend [C_NREG];
    logic [ADDR_W-1:0]  w_rx_idx  [2];
    logic [DATA_W-1:0]  w_rx_raw  [2];
    logic [DATA_W-1:0]  w_rx_data [2];
    logic [1:0]         w_rx_busy;
    logic [1:0]         w_byp;

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        w_in_valid   = {b_valid, a_valid};
        w_in_rd[0]   = a_rd;
        w_in_rd[1]   = b_rd;
        w_in_data[0] = a_data;
        w_in_data[1] = b_data;
        for (int q = 0; q < 2; q++) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_slot_vld[q][i] = {1'b0, C_PTR_W'(C_PTR_W'(i) - r_rp[q])} < r_cnt[q];
            end
        end
    end

    always_comb begin
        for (int q = 0; q < 2; q++) begin
            w_other_has[q] = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_slot_vld[1-q][i] && (r_rd[1-q][i] == w_in_rd[q])) begin
                    w_other_has[q] = 1'b1;
                end
            end
            w_full[q]     = (r_cnt[q] == C_FULL);
            w_ready[q]    = !reset && !w_full[q] && !((w_in_rd[q] != '0) && w_other_has[q]);
            w_push[q]     = w_in_valid[q] && w_ready[q];
            w_head_vld[q] = (r_cnt[q] != '0);
        end
    end

    assign a_ready = w_ready[0];
    assign b_ready = w_ready[1];

    always_comb begin
        w_gnt_vld = w_head_vld[0] || w_head_vld[1];
        if (w_head_vld[0] && w_head_vld[1]) begin
            w_gnt = (r_pri == PRI_B);
        end else begin
            w_gnt = !w_head_vld[0];
        end
        w_pop = '0;
        if (!reset && w_gnt_vld) begin
            w_pop[w_gnt] = 1'b1;
        end
        w_head_rd   = r_rd[w_gnt][r_rp[w_gnt]];
        w_head_data = r_data[w_gnt][r_rp[w_gnt]];
        // Entries for register 0 are consumed without touching the register file.
        rf_rw      = (w_pop != '0) && (w_head_rd != '0);
        rf_rd      = rf_rw ? w_head_rd : '0;
        rf_rd_data = rf_rw ? w_head_data : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pri <= PRI_A;
            for (int q = 0; q < 2; q++) begin
                r_wp[q]  <= '0;
                r_rp[q]  <= '0;
                r_cnt[q] <= '0;
            end
        end else begin
            if (w_gnt_vld) begin
                r_pri <= w_gnt ? PRI_A : PRI_B;
            end
            for (int q = 0; q < 2; q++) begin
                if (w_push[q]) begin
                    r_rd[q][r_wp[q]]   <= w_in_rd[q];
                    r_data[q][r_wp[q]] <= w_in_data[q];
                    r_wp[q]            <= r_wp[q] + C_PTR_W'(1);
                end
                if (w_pop[q]) begin
                    r_rp[q] <= r_rp[q] + C_PTR_W'(1);
                end
                if (w_push[q] && !w_pop[q]) begin
                    r_cnt[q] <= r_cnt[q] + C_CNT_W'(1);
                end else if (!w_push[q] && w_pop[q]) begin
                    r_cnt[q] <= r_cnt[q] - C_CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < C_NREG; r++) begin
            w_pend[r] = '0;
            for (int q = 0; q < 2; q++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_slot_vld[q][i] && (r_rd[q][i] == ADDR_W'(r))) begin
                        w_pend[r] = w_pend[r] + C_PEND_W'(1);
                    end
                end
            end
        end
    end

    // Forwarding is only safe when the retiring write is the sole pending one.
    always_comb begin
        w_rx_idx[0] = rs;
        w_rx_idx[1] = rt;
        w_rx_raw[0] = rf_rs_data;
        w_rx_raw[1] = rf_rt_data;
        for (int p = 0; p < 2; p++) begin
            w_byp[p] = 1'b0;
`ifdef REG_WB_BYPASS_EN
            w_byp[p] = rf_rw && (rf_rd == w_rx_idx[p]) &&
                       (w_pend[w_rx_idx[p]] == C_PEND_W'(1));
`endif
            if (w_rx_idx[p] == '0) begin
                w_rx_data[p] = '0;
                w_rx_busy[p] = 1'b0;
            end else if (w_byp[p]) begin
                w_rx_data[p] = rf_rd_data;
                w_rx_busy[p] = 1'b0;
            end else begin
                w_rx_data[p] = w_rx_raw[p];
                w_rx_busy[p] = !reset && (w_pend[w_rx_idx[p]] != '0);
            end
        end
    end

    assign rs_data = w_rx_data[0];
    assign rt_data = w_rx_data[1];
    assign rs_busy = w_rx_busy[0];
    assign rt_busy = w_rx_busy[1];
    assign idle    = reset || ((r_cnt[0] == '0) && (r_cnt[1] == '0));

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_reg_wb_arbiter                                               |
// | Directed vector bench for reg_wb_arbiter (both REG_WB_BYPASS_EN builds). |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_reg_wb_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_valid, b_valid;
    logic       a_ready, b_ready;
    logic [2:0] a_rd, b_rd, rs, rt, rf_rd;
    logic [7:0] a_data, b_data, rf_rs_data, rf_rt_data, rf_rd_data, rs_data, rt_data;
    logic       rf_rw, rs_busy, rt_busy, idle;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter #(.DATA_W(8), .ADDR_W(3), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .rf_rw(rf_rw), .rf_rd(rf_rd), .rf_rd_data(rf_rd_data),
        .rs(rs), .rt(rt), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
        .rs_data(rs_data), .rt_data(rt_data), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .idle(idle)
    );

    typedef struct {
        logic       rst, av, bv;
        logic [2:0] ard, brd, rs, rt;
        logic [7:0] adat, bdat, rsraw, rtraw;
        logic       ar, br, rw;
        logic [2:0] wrd;
        logic [7:0] wdat;
        logic       rsb, rtb;     // busy without forwarding
        logic [7:0] rsd, rtd;     // read data without forwarding
        logic       rsbyp, rtbyp; // forwarding build: port takes the retiring write
        logic       idl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int rst, av, ard, adat, bv, brd, bdat, rs_i, rt_i,
                                rsraw, rtraw, ar, br, rw, wrd, wdat, rsb, rtb, rsd, rtd,
                                rsbyp, rtbyp, idl);
        vec_t v;
        v.rst = 1'(rst);  v.av = 1'(av);  v.ard = 3'(ard);  v.adat = 8'(adat);
        v.bv = 1'(bv);    v.brd = 3'(brd); v.bdat = 8'(bdat);
        v.rs = 3'(rs_i);  v.rt = 3'(rt_i); v.rsraw = 8'(rsraw); v.rtraw = 8'(rtraw);
        v.ar = 1'(ar);    v.br = 1'(br);   v.rw = 1'(rw);  v.wrd = 3'(wrd); v.wdat = 8'(wdat);
        v.rsb = 1'(rsb);  v.rtb = 1'(rtb); v.rsd = 8'(rsd); v.rtd = 8'(rtd);
        v.rsbyp = 1'(rsbyp); v.rtbyp = 1'(rtbyp); v.idl = 1'(idl);
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, av, input logic [2:0] ard, input logic [7:0] adat,
                         input logic bv, input logic [2:0] brd, input logic [7:0] bdat,
                         input logic [2:0] rs_i, rt_i, input logic [7:0] rsraw, rtraw);
        @(negedge clk);
        reset = rst; a_valid = av; a_rd = ard; a_data = adat;
        b_valid = bv; b_rd = brd; b_data = bdat;
        rs = rs_i; rt = rt_i; rf_rs_data = rsraw; rf_rt_data = rtraw;
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic       e_rsb, e_rtb;
        logic [7:0] e_rsd, e_rtd;
        drive(v.rst, v.av, v.ard, v.adat, v.bv, v.brd, v.bdat, v.rs, v.rt, v.rsraw, v.rtraw);
        e_rsb = v.rsb; e_rtb = v.rtb; e_rsd = v.rsd; e_rtd = v.rtd;
`ifdef REG_WB_BYPASS_EN
        if (v.rsbyp) begin e_rsb = 1'b0; e_rsd = v.wdat; end
        if (v.rtbyp) begin e_rtb = 1'b0; e_rtd = v.wdat; end
`endif
        n_vec++;
        chk("a_ready", idx, 8'(a_ready), 8'(v.ar));
        chk("b_ready", idx, 8'(b_ready), 8'(v.br));
        chk("rf_rw", idx, 8'(rf_rw), 8'(v.rw));
        chk("rf_rd", idx, 8'(rf_rd), 8'(v.wrd));
        chk("rf_rd_data", idx, rf_rd_data, v.wdat);
        chk("rs_busy", idx, 8'(rs_busy), 8'(e_rsb));
        chk("rt_busy", idx, 8'(rt_busy), 8'(e_rtb));
        chk("rs_data", idx, rs_data, e_rsd);
        chk("rt_data", idx, rt_data, e_rtd);
        chk("idle", idx, 8'(idle), 8'(v.idl));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        a_rd = '0; b_rd = '0; a_data = '0; b_data = '0;
        rs = '0; rt = '0; rf_rs_data = 8'hC3; rf_rt_data = 8'h3C;

        //        rst av ard adat  bv brd bdat  rs rt rsraw rtraw | ar br rw wrd wdat  rsb rtb rsd   rtd  rsbyp rtbyp idl
        // reset held with a_valid high
        tbl.push_back(mk(1, 1, 1, 'h11, 0, 0, 'h00, 3, 0, 'hC3, 'h3C, 0, 0, 0, 0, 'h00, 0, 0, 'hC3, 'h00, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 'h11, 0, 0, 'h00, 3, 0, 'hC3, 'h3C, 0, 0, 0, 0, 'h00, 0, 0, 'hC3, 'h00, 0, 0, 1));
        // single write r3=5A
        tbl.push_back(mk(0, 1, 3, 'h5A, 0, 0, 'h00, 3, 0, 'hC3, 'h3C, 1, 1, 0, 0, 'h00, 0, 0, 'hC3, 'h00, 0, 0, 1));
        tbl.push_back(mk(0, 0, 3, 'h5A, 0, 0, 'h00, 3, 0, 'hC3, 'h3C, 1, 1, 1, 3, 'h5A, 1, 0, 'hC3, 'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 'h00, 0, 0, 'h00, 3, 0, 'h5A, 'h3C, 1, 1, 0, 0, 'h00, 0, 0, 'h5A, 'h00, 0, 0, 1));
        // reset to restore the A-first pointer
        tbl.push_back(mk(1, 0, 0, 'h00, 0, 0, 'h00, 3, 0, 'hC3, 'h3C, 0, 0, 0, 0, 'h00, 0, 0, 'hC3, 'h00, 0, 0, 1));
        // contention: A r1=11, B r2=22, four each
        tbl.push_back(mk(0, 1, 1, 'h11, 1, 2, 'h22, 1, 2, 'hC3, 'h3C, 1, 1, 0, 0, 'h00, 0, 0, 'hC3, 'h3C, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 'h11, 1, 2, 'h22, 1, 2, 'hC3, 'h3C, 1, 1, 1, 1, 'h11, 1, 1, 'hC3, 'h3C, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 'h11, 1, 2, 'h22, 1, 2, 'hC3, 'h3C, 1, 0, 1, 2, 'h22, 1, 1, 'hC3, 'h3C, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 'h11, 1, 2, 'h22, 1, 2, 'hC3, 'h3C, 0, 1, 1, 1, 'h11, 1, 1, 'hC3, 'h3C, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 'h11, 1, 2, 'h22, 1, 2, 'hC3, 'h3C, 1, 0, 1, 2, 'h22, 1, 1, 'hC3, 'h3C, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h11, 1, 2, 'h22, 1, 2, 'hC3, 'h3C, 0, 1, 1, 1, 'h11, 1, 1, 'hC3, 'h3C, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h11, 0, 2, 'h22, 1, 2, 'hC3, 'h3C, 1, 0, 1, 2, 'h22, 1, 1, 'hC3, 'h3C, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h11, 0, 2, 'h22, 1, 2, 'hC3, 'h3C, 1, 1, 1, 1, 'h11, 1, 1, 'hC3, 'h3C, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 'h11, 0, 2, 'h22, 1, 2, 'hC3, 'h3C, 1, 1, 1, 2, 'h22, 0, 1, 'hC3, 'h3C, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 'h11, 0, 2, 'h22, 1, 2, 'hC3, 'h3C, 1, 1, 0, 0, 'h00, 0, 0, 'hC3, 'h3C, 0, 0, 1));
        // WAW: B holds r5, A offers r5
        tbl.push_back(mk(0, 1, 7, 'h70, 1, 5, 'h55, 5, 7, 'hC3, 'h3C, 1, 1, 0, 0, 'h00, 0, 0, 'hC3, 'h3C, 0, 0, 1));
        tbl.push_back(mk(0, 1, 5, 'hA5, 0, 0, 'h00, 5, 7, 'hC3, 'h3C, 0, 1, 1, 7, 'h70, 1, 1, 'hC3, 'h3C, 0, 1, 0));
        tbl.push_back(mk(0, 1, 5, 'hA5, 0, 0, 'h00, 5, 7, 'hC3, 'h3C, 0, 1, 1, 5, 'h55, 1, 0, 'hC3, 'h3C, 1, 0, 0));
        tbl.push_back(mk(0, 1, 5, 'hA5, 0, 0, 'h00, 5, 7, 'hC3, 'h3C, 1, 1, 0, 0, 'h00, 0, 0, 'hC3, 'h3C, 0, 0, 1));
        tbl.push_back(mk(0, 0, 5, 'hA5, 0, 0, 'h00, 5, 7, 'hC3, 'h3C, 1, 1, 1, 5, 'hA5, 1, 0, 'hC3, 'h3C, 1, 0, 0));
        // full A (r0=FF, r4=44) while B competes
        tbl.push_back(mk(0, 1, 0, 'hFF, 1, 6, 'h61, 4, 6, 'hC3, 'h3C, 1, 1, 0, 0, 'h00, 0, 0, 'hC3, 'h3C, 0, 0, 1));
        tbl.push_back(mk(0, 1, 4, 'h44, 1, 6, 'h62, 4, 6, 'hC3, 'h3C, 1, 1, 1, 6, 'h61, 0, 1, 'hC3, 'h3C, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 'h99, 0, 0, 'h00, 4, 6, 'hC3, 'h3C, 0, 1, 0, 0, 'h00, 1, 1, 'hC3, 'h3C, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 'h00, 0, 0, 'h00, 4, 6, 'hC3, 'h3C, 1, 1, 1, 6, 'h62, 1, 1, 'hC3, 'h3C, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 'h00, 0, 0, 'h00, 4, 6, 'hC3, 'h3C, 1, 1, 1, 4, 'h44, 1, 0, 'hC3, 'h3C, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 'h00, 0, 0, 'h00, 4, 6, 'hC3, 'h3C, 1, 1, 0, 0, 'h00, 0, 0, 'hC3, 'h3C, 0, 0, 1));
        // forwarding of r6=66 to rs
        tbl.push_back(mk(0, 0, 0, 'h00, 1, 6, 'h66, 6, 0, 'hC3, 'h3C, 1, 1, 0, 0, 'h00, 0, 0, 'hC3, 'h00, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 'h00, 0, 6, 'h66, 6, 0, 'hC3, 'h3C, 1, 1, 1, 6, 'h66, 1, 0, 'hC3, 'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 'h00, 0, 6, 'h66, 6, 0, 'hC3, 'h3C, 1, 1, 0, 0, 'h00, 0, 0, 'hC3, 'h00, 0, 0, 1));

        @(negedge clk);
        for (int k = 0; k < tbl.size(); k++) begin
            run_vec(tbl[k], k);
        end

        // Reset mid-operation: queued r3/r2 entries must never be written.
        drive(0, 1, 3, 8'h31, 1, 2, 8'h21, 3, 2, 8'hC3, 8'h3C);
        drive(1, 0, 0, 8'h00, 0, 0, 8'h00, 3, 2, 8'hC3, 8'h3C);
        n_vec++;
        chk("rst_mid_rw", 100, 8'(rf_rw), 8'h00);
        chk("rst_mid_ready", 100, 8'(a_ready), 8'h00);
        chk("rst_mid_idle", 100, 8'(idle), 8'h01);
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 8'h00, 0, 0, 8'h00, 3, 2, 8'hC3, 8'h3C);
            n_vec++;
            chk("post_rst_rw", 101 + k, 8'(rf_rw), 8'h00);
            chk("post_rst_idle", 101 + k, 8'(idle), 8'h01);
            chk("post_rst_busy", 101 + k, 8'({rs_busy, rt_busy}), 8'h00);
        end

        // Same-register writes from A retire in acceptance order.
        drive(0, 1, 3, 8'h01, 0, 0, 8'h00, 0, 0, 8'hC3, 8'h3C);
        n_vec++;
        chk("ord0_rw", 110, 8'(rf_rw), 8'h00);
        drive(0, 1, 3, 8'h02, 0, 0, 8'h00, 0, 0, 8'hC3, 8'h3C);
        n_vec++;
        chk("ord1_ready", 111, 8'(a_ready), 8'h01);
        chk("ord1_rw", 111, 8'(rf_rw), 8'h01);
        chk("ord1_data", 111, rf_rd_data, 8'h01);
        drive(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'hC3, 8'h3C);
        n_vec++;
        chk("ord2_rd", 112, 8'(rf_rd), 8'h03);
        chk("ord2_data", 112, rf_rd_data, 8'h02);
        drive(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'hC3, 8'h3C);
        n_vec++;
        chk("ord3_rw", 113, 8'(rf_rw), 8'h00);
        chk("ord3_idle", 113, 8'(idle), 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
